sim_test_controller: RTL and testbench
======================================

// Module: sim_test_controller
// PURPOSE
//   Synthesisable test supervisor for the RV32I core; replaces a fixed-delay bench timeout.
//   - Sequences the core reset.
//   - Counts cycles and retired instructions.
//   - Snoops data-memory writes for TOHOST (pass/fail) and CONSOLE (character output).
//   - Enforces a watchdog.
//   - Halts the core once a terminal state is reached.
//   Sits beside the core's bus, at the same level as the register file and data memory.
// PARAMETERS
//   ADDR_W        32            width of snooped byte address
//   CNT_W         32            width of cycle/instret counters
//   RESET_CYCLES  4             cycles core_rst held high after rst deasserts (>=1)
//   MAX_CYCLES    200           watchdog limit in RUN cycles (>=1, < 2**CNT_W)
//   TOHOST_ADDR   32'h0000_3FF0 word address of the pass/fail mailbox
//   CONSOLE_ADDR  32'h0000_3FF4 word address of the character output port
// PORTS
//   clk            in   1       single clock, rising edge
//   rst            in   1       synchronous, active-high reset
//   mem_we         in   1       data-memory write strobe from core
//   mem_addr       in   ADDR_W  data-memory write address
//   mem_wdata      in   32      data-memory write data
//   instr_retire   in   1       one-cycle pulse per retired instruction
//   core_rst       out  1       reset to core, regfile and memory
//   core_halt      out  1       clock-enable kill to core; high in terminal states
//   done           out  1       high in PASS, FAIL or TIMEOUT
//   pass           out  1       high only in PASS
//   fail_code      out  31     mem_wdata[31:1] of the failing TOHOST write; else 0
//   cycle_count    out  CNT_W  RUN cycles elapsed
//   instret_count  out  CNT_W  retired instructions in RUN
//   cons_valid     out  1       one-cycle strobe, character available
//   cons_data      out  8       character (mem_wdata[7:0])
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//   - State goes to RESET and the reset counter loads 0.
//   - core_rst=1; core_halt, done, pass, cons_valid = 0.
//   - fail_code, cycle_count, instret_count, cons_data = 0.
//   RESET:
//   - core_rst=1; snooped writes and retire pulses are ignored.
//   - Transitions to RUN after RESET_CYCLES consecutive clocks with rst=0.
//   - core_rst falls on the same edge.
//   RUN:
//   - cycle_count increments each clock.
//   - instret_count increments when instr_retire=1.
//   TOHOST write (mem_we && mem_addr[ADDR_W-1:2]==TOHOST_ADDR[ADDR_W-1:2]), evaluated at posedge:
//   - wdata==1: next state PASS.
//   - wdata[0]==1 and wdata!=1: next state FAIL, fail_code<=wdata[31:1].
//   - wdata[0]==0: ignored, no state change.
//   Latency: a write sampled at edge N gives done=1 after edge N (registered, 1 cycle).
//   CONSOLE write in any state except RESET:
//   - cons_valid=1 and cons_data=wdata[7:0] for exactly one cycle after the sampling edge.
//   - Back-to-back writes give back-to-back strobes; there is no buffering.
//   Watchdog:
//   - At the edge where cycle_count==MAX_CYCLES-1 in RUN with no decisive TOHOST write, next state is TIMEOUT.
//   - A decisive TOHOST write on the same edge wins: PASS or FAIL, not TIMEOUT.
//   Terminal states (PASS, FAIL, TIMEOUT):
//   - Sticky until rst; core_halt=1; done=1.
//   - Counters freeze; TOHOST writes are ignored.
//   Counters saturate at all-ones and never wrap.
//   rst mid-RUN or in a terminal state: full return to RESET; all outputs take their reset values.
//   TOHOST and CONSOLE matches compare the word address only; mem_addr[1:0] is ignored.
// STRUCTURE
//   Shared package tc_pkg:
//   - state encoding RESET/RUN/PASS/FAIL/TIMEOUT (3 bits).
//   - TOHOST_ADDR/CONSOLE_ADDR defaults; the PASS code constant 1.
//   Sub-module sat_counter #(W) (clk, rst, en, q):
//   - saturating up-counter.
//   - instantiated for cycle_count, instret_count, and the reset sequencer.
//   The top level holds the FSM, the address decode and the console register.
// TESTING
//   1. rst high 3 clk, low -> core_rst high exactly 4 more clk; cycle_count==0 until RUN.
//   2. RUN 10 clk, then TOHOST write 32'h1 -> next clk done=1, pass=1, core_halt=1, cycle_count==10 frozen.
//   3. TOHOST write 32'h7 -> FAIL; fail_code==3, pass=0.
//   4. TOHOST write 32'h4 -> ignored; no writes -> TIMEOUT; cycle_count==MAX_CYCLES-1 (199) frozen, pass=0.
//   5. TOHOST 32'h1 on the watchdog edge -> PASS, not TIMEOUT.
//   6. CONSOLE writes 'O','K' on consecutive clk -> two strobes, cons_data 8'h4F then 8'h4B.
//      Same writes during RESET -> no strobe.
//      rst asserted in PASS -> all outputs return to reset values.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the simulation test controller: state encoding,
// default mailbox addresses and the TOHOST pass code.
package tc_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } tc_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_3FF0;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_3FF4;
  localparam logic [31:0] PASS_CODE        = 32'h0000_0001;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sim_test_controller.sv
// Test supervisor for the RV32I core: sequences core reset, counts cycles and
// retired instructions, snoops TOHOST/CONSOLE writes and enforces a watchdog.
module sim_test_controller
  import tc_pkg::*;
#(
  parameter int               ADDR_W       = 32,
  parameter int               CNT_W        = 32,
  parameter int               RESET_CYCLES = 4,
  parameter int               MAX_CYCLES   = 200,
  parameter logic [31:0]      TOHOST_ADDR  = TOHOST_ADDR_DEF,
  parameter logic [31:0]      CONSOLE_ADDR = CONSOLE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              instr_retire,
  output logic              core_rst,
  output logic              core_halt,
  output logic              done,
  output logic              pass,
  output logic [30:0]       fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  output logic              cons_valid,
  output logic [7:0]        cons_data
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  // Byte-lane bits are masked off so any byte within the mailbox word matches.
  localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] TOHOST_WORD  = ADDR_W'(TOHOST_ADDR) & WORD_MASK;
  localparam logic [ADDR_W-1:0] CONSOLE_WORD = ADDR_W'(CONSOLE_ADDR) & WORD_MASK;

  tc_state_e        state, next_state;
  logic [RST_W-1:0] rst_cnt;
  logic             tohost_hit, console_hit, decisive, wd_expire;
  logic             run_stay, retire_en, cons_fire;

  always_comb begin
    tohost_hit  = mem_we && ((mem_addr & WORD_MASK) == TOHOST_WORD);
    console_hit = mem_we && ((mem_addr & WORD_MASK) == CONSOLE_WORD);
    decisive    = tohost_hit && mem_wdata[0];
    wd_expire   = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET: begin
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) next_state = ST_RUN;
      end
      ST_RUN: begin
        // A decisive TOHOST write outranks the watchdog on the same edge.
        if (decisive) begin
          next_state = (mem_wdata == PASS_CODE) ? ST_PASS : ST_FAIL;
        end else if (wd_expire) begin
          next_state = ST_TIMEOUT;
        end
      end
      default: next_state = state;
    endcase
  end

  always_comb begin
    core_rst  = 1'b0;
    core_halt = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      ST_RESET:   core_rst = 1'b1;
      ST_PASS:    begin core_halt = 1'b1; done = 1'b1; pass = 1'b1; end
      ST_FAIL:    begin core_halt = 1'b1; done = 1'b1; end
      ST_TIMEOUT: begin core_halt = 1'b1; done = 1'b1; end
      default:    core_rst = 1'b0;
    endcase
  end

  // The terminating edge itself does not count, so counters freeze at the value seen then.
  always_comb begin
    run_stay  = (state == ST_RUN) && (next_state == ST_RUN);
    retire_en = run_stay && instr_retire;
    cons_fire = console_hit && (state != ST_RESET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_code <= '0;
    end else if ((state == ST_RUN) && (next_state == ST_FAIL)) begin
      fail_code <= mem_wdata[31:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cons_valid <= 1'b0;
      cons_data  <= '0;
    end else begin
      cons_valid <= cons_fire;
      if (cons_fire) cons_data <= mem_wdata[7:0];
    end
  end

  sat_counter #(.W(RST_W)) u_rst_seq (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_RESET),
    .q   (rst_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (run_stay),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .rst (rst),
    .en  (retire_en),
    .q   (instret_count)
  );

endmodule

// File: tb/tb_sim_test_controller.sv
// Directed bench for sim_test_controller with a fixed-latency console scoreboard.
module tb_sim_test_controller;

  localparam logic [31:0] TOHOST  = 32'h0000_3FF0;
  localparam logic [31:0] CONSOLE = 32'h0000_3FF4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        instr_retire = 1'b0;
  logic        core_rst, core_halt, done, pass, cons_valid;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, instret_count;
  logic [7:0]  cons_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] cons_q[$];

  sim_test_controller dut (
    .clk           (clk),
    .rst           (rst),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .instr_retire  (instr_retire),
    .core_rst      (core_rst),
    .core_halt     (core_halt),
    .done          (done),
    .pass          (pass),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count),
    .instret_count (instret_count),
    .cons_valid    (cons_valid),
    .cons_data     (cons_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every queued character must appear as a strobe on the very next edge.
  task automatic tick();
    logic exp_v;
    logic [7:0] exp_d;
    @(posedge clk);
    #1;
    exp_v = (cons_q.size() > 0);
    chk("cons_valid", {63'd0, cons_valid}, {63'd0, exp_v});
    if (exp_v) begin
      exp_d = cons_q.pop_front();
      chk("cons_data", {56'd0, cons_data}, {56'd0, exp_d});
    end
  endtask

  task automatic idle();
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; instr_retire = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
  endtask

  task automatic cons_wr(input logic [7:0] c, input bit strobe_expected);
    wr(CONSOLE, {24'd0, c});
    if (strobe_expected) cons_q.push_back(c);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_rst"}, {63'd0, core_rst}, 64'd1);
    chk({tag, "_core_halt"}, {63'd0, core_halt}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
    chk({tag, "_fail_code"}, {33'd0, fail_code}, 64'd0);
    chk({tag, "_cycle"}, {32'd0, cycle_count}, 64'd0);
    chk({tag, "_instret"}, {32'd0, instret_count}, 64'd0);
    chk({tag, "_cons_data"}, {56'd0, cons_data}, 64'd0);
  endtask

  task automatic reset_and_run();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rr_core_rst", {63'd0, core_rst}, 64'd0);
  endtask

  initial begin
    int n;
    // 1: reset sequencing; console writes and retires in RESET are ignored
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    instr_retire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cons_wr((i % 2 == 0) ? 8'h4F : 8'h4B, 1'b0);
      tick();
      chk("rseq_core_rst", {63'd0, core_rst}, 64'd1);
      chk("rseq_cycle", {32'd0, cycle_count}, 64'd0);
    end
    tick();
    chk("rseq_release", {63'd0, core_rst}, 64'd0);
    chk("rseq_instret", {32'd0, instret_count}, 64'd0);
    idle();

    // 2: console OK back-to-back, 10 RUN cycles, then PASS
    cons_wr(8'h4F, 1'b1); instr_retire = 1'b1; tick();
    cons_wr(8'h4B, 1'b1); tick();
    idle();
    for (int i = 2; i < 10; i++) begin
      instr_retire = (i == 5);
      tick();
    end
    idle();
    chk("run_cycle10", {32'd0, cycle_count}, 64'd10);
    chk("run_done_low", {63'd0, done}, 64'd0);
    wr(TOHOST, 32'h1); tick(); idle();
    chk("pass_done", {63'd0, done}, 64'd1);
    chk("pass_pass", {63'd0, pass}, 64'd1);
    chk("pass_halt", {63'd0, core_halt}, 64'd1);
    chk("pass_cycle", {32'd0, cycle_count}, 64'd10);
    chk("pass_instret", {32'd0, instret_count}, 64'd3);
    instr_retire = 1'b1; wr(TOHOST, 32'h7); tick(); idle();
    chk("pass_sticky", {63'd0, pass}, 64'd1);
    chk("pass_frozen_cycle", {32'd0, cycle_count}, 64'd10);
    chk("pass_frozen_instret", {32'd0, instret_count}, 64'd3);
    chk("pass_no_fail_code", {33'd0, fail_code}, 64'd0);
    cons_wr(8'h21, 1'b1); tick(); idle();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_outputs("rst_in_pass");

    // 3: FAIL with byte-offset address; later writes ignored
    reset_and_run();
    for (int i = 0; i < 5; i++) tick();
    wr(TOHOST + 32'd3, 32'h7); tick(); idle();
    chk("fail_done", {63'd0, done}, 64'd1);
    chk("fail_pass", {63'd0, pass}, 64'd0);
    chk("fail_code", {33'd0, fail_code}, 64'd3);
    chk("fail_cycle", {32'd0, cycle_count}, 64'd5);
    wr(TOHOST, 32'h1); tick(); idle();
    chk("fail_sticky_pass", {63'd0, pass}, 64'd0);
    chk("fail_sticky_code", {33'd0, fail_code}, 64'd3);

    // 4: even TOHOST value and foreign address ignored, then watchdog
    reset_and_run();
    wr(TOHOST, 32'h4); tick(); idle();
    chk("even_ignored", {63'd0, done}, 64'd0);
    wr(TOHOST + 32'd8, 32'h1); tick(); idle();
    chk("foreign_ignored", {63'd0, done}, 64'd0);
    n = 2;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("timeout_edges", 64'(n), 64'd200);
    chk("timeout_done", {63'd0, done}, 64'd1);
    chk("timeout_pass", {63'd0, pass}, 64'd0);
    chk("timeout_halt", {63'd0, core_halt}, 64'd1);
    chk("timeout_cycle", {32'd0, cycle_count}, 64'd199);
    tick();
    chk("timeout_frozen", {32'd0, cycle_count}, 64'd199);

    // 5: PASS on the watchdog edge beats TIMEOUT
    reset_and_run();
    for (int i = 0; i < 199; i++) tick();
    chk("wd_edge_pre_done", {63'd0, done}, 64'd0);
    chk("wd_edge_pre_cycle", {32'd0, cycle_count}, 64'd199);
    wr(TOHOST, 32'h1); tick(); idle();
    chk("wd_edge_pass", {63'd0, pass}, 64'd1);
    chk("wd_edge_cycle", {32'd0, cycle_count}, 64'd199);

    chk("cons_q_empty", 64'(cons_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
